// File: rtl/issue_select_arbiter_if.sv
// Request/grant bundle between the RS wakeup logic and the issue select stage.
interface issue_select_arbiter_if #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = 3,
  parameter int LAT_W   = 3
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LAT_W-1:0] lat;
  logic                     stall;
  logic                     flush;
  logic [NUM_REQ-1:0]       gnt_vec;
  logic                     gnt1_valid;
  logic [IDX_W-1:0]         gnt1_idx;
  logic                     gnt2_valid;
  logic [IDX_W-1:0]         gnt2_idx;
  logic [1:0]               wb_cnt;

  modport master (
    output req, lat, stall, flush,
    input  gnt_vec, gnt1_valid, gnt1_idx, gnt2_valid, gnt2_idx, wb_cnt
  );

  modport slave (
    input  req, lat, stall, flush,
    output gnt_vec, gnt1_valid, gnt1_idx, gnt2_valid, gnt2_idx, wb_cnt
  );
endinterface

// File: rtl/issue_select_arbiter.sv
// Dual round-robin issue select with a writeback-slot reservation table (max 2 results/cycle).
// Optional performance counters are enabled by defining ISSUE_SEL_PERF_CNT_EN.
module issue_select_arbiter #(
  parameter int NUM_REQ     = 8,
  parameter int IDX_W       = 3,
  parameter int MAX_LATENCY = 4,
  parameter int LAT_W       = 3
) (
  input  logic clk,
  input  logic reset,
  issue_select_arbiter_if.slave bus
`ifdef ISSUE_SEL_PERF_CNT_EN
  ,
  output logic [31:0] perf_grant_cnt,
  output logic [31:0] perf_block_cnt
`endif
);

  logic [IDX_W-1:0] rr_q, rr_d;
  logic [1:0]       res_q   [MAX_LATENCY];
  logic [1:0]       res_d   [MAX_LATENCY];
  logic [1:0]       res_ext [MAX_LATENCY+1];

  logic [LAT_W-1:0] lat_e   [NUM_REQ];
  logic             legal_e [NUM_REQ];
  logic [1:0]       cap_e   [NUM_REQ];

  logic             g1v, g2v, hit1;
  logic [IDX_W-1:0] g1i, g2i, idx_t;
  logic [LAT_W-1:0] g1lat, g2lat;
  logic [NUM_REQ-1:0] gvec;

  // Per-entry latency decode and remaining capacity in the targeted writeback slot
  always_comb begin
    for (int unsigned d = 0; d < MAX_LATENCY; d++) res_ext[d] = res_q[d];
    res_ext[MAX_LATENCY] = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      lat_e[i]   = bus.lat[i*LAT_W +: LAT_W];
      legal_e[i] = (lat_e[i] != '0) && (lat_e[i] <= LAT_W'(MAX_LATENCY));
      cap_e[i]   = '0;
      for (int unsigned d = 1; d <= MAX_LATENCY; d++)
        if (lat_e[i] == LAT_W'(d)) cap_e[i] = res_ext[d];
    end
  end

  // Round-robin scan; the second pick rechecks slot capacity against the first
  always_comb begin
    g1v   = 1'b0;
    g2v   = 1'b0;
    g1i   = '0;
    g2i   = '0;
    g1lat = '0;
    g2lat = '0;
    hit1  = 1'b0;
    idx_t = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx_t = IDX_W'((32'(rr_q) + k) % NUM_REQ);
      hit1  = g1v && (g1lat == lat_e[idx_t]);
      if (!bus.stall && !reset && bus.req[idx_t] && legal_e[idx_t] &&
          (({1'b0, cap_e[idx_t]} + {2'b00, hit1}) < 3'd2)) begin
        if (!g1v) begin
          g1v   = 1'b1;
          g1i   = idx_t;
          g1lat = lat_e[idx_t];
        end else if (!g2v) begin
          g2v   = 1'b1;
          g2i   = idx_t;
          g2lat = lat_e[idx_t];
        end
      end
    end
    gvec = '0;
    if (g1v) gvec[g1i] = 1'b1;
    if (g2v) gvec[g2i] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (g2v)      rr_d = (g2i == IDX_W'(NUM_REQ-1)) ? '0 : g2i + 1'b1;
    else if (g1v) rr_d = (g1i == IDX_W'(NUM_REQ-1)) ? '0 : g1i + 1'b1;
    for (int unsigned d = 0; d < MAX_LATENCY; d++) begin
      res_d[d] = res_ext[d+1]
               + {1'b0, (g1v && g1lat == LAT_W'(d+1))}
               + {1'b0, (g2v && g2lat == LAT_W'(d+1))};
      if (bus.flush) res_d[d] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= '0;
      for (int unsigned d = 0; d < MAX_LATENCY; d++) res_q[d] <= '0;
    end else begin
      rr_q <= rr_d;
      for (int unsigned d = 0; d < MAX_LATENCY; d++) res_q[d] <= res_d[d];
    end
  end

  assign bus.gnt_vec    = gvec;
  assign bus.gnt1_valid = g1v;
  assign bus.gnt1_idx   = g1i;
  assign bus.gnt2_valid = g2v;
  assign bus.gnt2_idx   = g2i;
  assign bus.wb_cnt     = res_q[0];

`ifdef ISSUE_SEL_PERF_CNT_EN
  logic       blk_any;
  logic [1:0] same;

  // An entry counts as blocked when only the writeback slot occupancy kept it out
  always_comb begin
    blk_any = 1'b0;
    same    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      same = {1'b0, (g1v && g1lat == lat_e[i])} + {1'b0, (g2v && g2lat == lat_e[i])};
      if (bus.req[i] && legal_e[i] && !gvec[i] &&
          (({1'b0, cap_e[i]} + {1'b0, same}) >= 3'd2))
        blk_any = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_grant_cnt <= '0;
      perf_block_cnt <= '0;
    end else begin
      if (!bus.stall && !bus.flush)
        perf_grant_cnt <= perf_grant_cnt + {31'd0, g1v} + {31'd0, g2v};
      if (!bus.stall && blk_any)
        perf_block_cnt <= perf_block_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_select_arbiter.sv
// Directed-vector bench for issue_select_arbiter with hand-computed expectations.
module tb_issue_select_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  issue_select_arbiter_if #(.NUM_REQ(8), .IDX_W(3), .LAT_W(3)) bif();

`ifdef ISSUE_SEL_PERF_CNT_EN
  logic [31:0] perf_grant_cnt, perf_block_cnt;
`endif

  issue_select_arbiter #(.NUM_REQ(8), .IDX_W(3), .MAX_LATENCY(4), .LAT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
`ifdef ISSUE_SEL_PERF_CNT_EN
    ,
    .perf_grant_cnt (perf_grant_cnt),
    .perf_block_cnt (perf_block_cnt)
`endif
  );

  always #5 clk = ~clk;

  // {gnt_vec, gnt1_valid, gnt1_idx, gnt2_valid, gnt2_idx}
  logic [15:0] gtup;
  assign gtup = {bif.gnt_vec, bif.gnt1_valid, bif.gnt1_idx, bif.gnt2_valid, bif.gnt2_idx};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] lat_all(input logic [2:0] v);
    return {8{v}};
  endfunction

  task automatic do_reset();
    reset = 1'b1; bif.req = '0; bif.stall = 1'b0; bif.flush = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bif.stall = 1'b0; bif.flush = 1'b0;
    bif.req = 8'hFF; bif.lat = lat_all(3'd1);
    step();
    #1;
    vec_cnt++;
    if (gtup !== 16'h0) begin err_cnt++; $display("FAIL reset_nogrant got %h want %h", gtup, 16'h0); end
    step();
    reset = 1'b0; bif.req = '0;
    #1;
    vec_cnt++;
    if (bif.wb_cnt !== 2'd0) begin err_cnt++; $display("FAIL reset_wb got %0d want 0", bif.wb_cnt); end
    vec_cnt++;
    if (gtup !== 16'h0) begin err_cnt++; $display("FAIL reset_idle got %h want %h", gtup, 16'h0); end
  endtask

  task automatic test_basic();
    bif.req = 8'b0000_0110; bif.lat = lat_all(3'd1);
    #1;
    vec_cnt++;
    if (gtup !== {8'h06, 1'b1, 3'd1, 1'b1, 3'd2}) begin
      err_cnt++; $display("FAIL basic_grant got %h want %h", gtup, {8'h06, 1'b1, 3'd1, 1'b1, 3'd2});
    end
    step();
    bif.req = '0;
    #1;
    vec_cnt++;
    if (bif.wb_cnt !== 2'd2) begin err_cnt++; $display("FAIL basic_wb got %0d want 2", bif.wb_cnt); end
  endtask

  task automatic test_rr_wrap();
    bif.req = 8'hFF; bif.lat = lat_all(3'd1);
    #1;
    vec_cnt++;
    if (gtup !== {8'h18, 1'b1, 3'd3, 1'b1, 3'd4}) begin
      err_cnt++; $display("FAIL rr_34 got %h want %h", gtup, {8'h18, 1'b1, 3'd3, 1'b1, 3'd4});
    end
    step();
    #1;
    vec_cnt++;
    if (gtup !== {8'h60, 1'b1, 3'd5, 1'b1, 3'd6}) begin
      err_cnt++; $display("FAIL rr_56 got %h want %h", gtup, {8'h60, 1'b1, 3'd5, 1'b1, 3'd6});
    end
    step();
    #1;
    vec_cnt++;
    if (gtup !== {8'h81, 1'b1, 3'd7, 1'b1, 3'd0}) begin
      err_cnt++; $display("FAIL rr_wrap got %h want %h", gtup, {8'h81, 1'b1, 3'd7, 1'b1, 3'd0});
    end
    vec_cnt++;
    if (bif.wb_cnt !== 2'd2) begin err_cnt++; $display("FAIL rr_wb got %0d want 2", bif.wb_cnt); end
    step();
    bif.req = '0;
  endtask

  task automatic test_capacity();
    logic [23:0] lv;
    do_reset();
    lv = '0; lv[0 +: 3] = 3'd3; lv[3 +: 3] = 3'd3;
    bif.req = 8'h03; bif.lat = lv;
    #1;
    vec_cnt++;
    if (gtup !== {8'h03, 1'b1, 3'd0, 1'b1, 3'd1}) begin
      err_cnt++; $display("FAIL cap_c0 got %h want %h", gtup, {8'h03, 1'b1, 3'd0, 1'b1, 3'd1});
    end
    step();
    lv[6 +: 3] = 3'd2; lv[9 +: 3] = 3'd1;
    bif.req = 8'h0C; bif.lat = lv;
    #1;
    vec_cnt++;
    if (gtup !== {8'h08, 1'b1, 3'd3, 1'b0, 3'd0}) begin
      err_cnt++; $display("FAIL cap_block got %h want %h", gtup, {8'h08, 1'b1, 3'd3, 1'b0, 3'd0});
    end
    step();
    bif.req = '0;
    #1;
    vec_cnt++;
    if (bif.wb_cnt !== 2'd1) begin err_cnt++; $display("FAIL cap_wb_c2 got %0d want 1", bif.wb_cnt); end
    step();
    vec_cnt++;
    if (bif.wb_cnt !== 2'd2) begin err_cnt++; $display("FAIL cap_wb_c3 got %0d want 2", bif.wb_cnt); end
    step();
    vec_cnt++;
    if (bif.wb_cnt !== 2'd0) begin err_cnt++; $display("FAIL cap_wb_c4 got %0d want 0", bif.wb_cnt); end
  endtask

  task automatic test_equal_lat();
    do_reset();
    bif.req = 8'h07; bif.lat = lat_all(3'd4);
    #1;
    vec_cnt++;
    if (gtup !== {8'h03, 1'b1, 3'd0, 1'b1, 3'd1}) begin
      err_cnt++; $display("FAIL eq_c0 got %h want %h", gtup, {8'h03, 1'b1, 3'd0, 1'b1, 3'd1});
    end
    step();
    bif.req = 8'h04;
    #1;
    vec_cnt++;
    if (gtup !== {8'h04, 1'b1, 3'd2, 1'b0, 3'd0}) begin
      err_cnt++; $display("FAIL eq_c1 got %h want %h", gtup, {8'h04, 1'b1, 3'd2, 1'b0, 3'd0});
    end
    step();
    bif.req = '0;
    step();
    step();
    vec_cnt++;
    if (bif.wb_cnt !== 2'd2) begin err_cnt++; $display("FAIL eq_wb_c4 got %0d want 2", bif.wb_cnt); end
    step();
    vec_cnt++;
    if (bif.wb_cnt !== 2'd1) begin err_cnt++; $display("FAIL eq_wb_c5 got %0d want 1", bif.wb_cnt); end
    step();
    vec_cnt++;
    if (bif.wb_cnt !== 2'd0) begin err_cnt++; $display("FAIL eq_wb_c6 got %0d want 0", bif.wb_cnt); end
  endtask

  task automatic test_illegal_lat();
    logic [23:0] lv;
    // rr_ptr is 3 here; entries 0..2 carry latencies 0, 5, 7
    lv = '0; lv[3 +: 3] = 3'd5; lv[6 +: 3] = 3'd7; lv[9 +: 3] = 3'd4;
    bif.req = 8'h0F; bif.lat = lv;
    #1;
    vec_cnt++;
    if (gtup !== {8'h08, 1'b1, 3'd3, 1'b0, 3'd0}) begin
      err_cnt++; $display("FAIL illegal_lat got %h want %h", gtup, {8'h08, 1'b1, 3'd3, 1'b0, 3'd0});
    end
    step();
    bif.req = '0;
  endtask

  task automatic test_stall();
    do_reset();
    bif.req = 8'h03; bif.lat = lat_all(3'd2);
    #1;
    vec_cnt++;
    if (gtup !== {8'h03, 1'b1, 3'd0, 1'b1, 3'd1}) begin
      err_cnt++; $display("FAIL stall_pre got %h want %h", gtup, {8'h03, 1'b1, 3'd0, 1'b1, 3'd1});
    end
    step();
    bif.stall = 1'b1; bif.req = 8'hFF; bif.lat = lat_all(3'd1);
    #1;
    vec_cnt++;
    if (gtup !== 16'h0) begin err_cnt++; $display("FAIL stall_g1 got %h want 0", gtup); end
    vec_cnt++;
    if (bif.wb_cnt !== 2'd0) begin err_cnt++; $display("FAIL stall_wb1 got %0d want 0", bif.wb_cnt); end
    step();
    vec_cnt++;
    if (gtup !== 16'h0) begin err_cnt++; $display("FAIL stall_g2 got %h want 0", gtup); end
    vec_cnt++;
    if (bif.wb_cnt !== 2'd2) begin err_cnt++; $display("FAIL stall_wb2 got %0d want 2", bif.wb_cnt); end
    step();
    vec_cnt++;
    if (bif.wb_cnt !== 2'd0) begin err_cnt++; $display("FAIL stall_wb3 got %0d want 0", bif.wb_cnt); end
    step();
    bif.stall = 1'b0;
    #1;
    vec_cnt++;
    if (gtup !== {8'h0C, 1'b1, 3'd2, 1'b1, 3'd3}) begin
      err_cnt++; $display("FAIL stall_rr got %h want %h", gtup, {8'h0C, 1'b1, 3'd2, 1'b1, 3'd3});
    end
    step();
    bif.req = '0;
  endtask

  task automatic test_flush();
    do_reset();
    bif.req = 8'h03; bif.lat = lat_all(3'd4);
    step();
    bif.flush = 1'b1; bif.req = 8'h30; bif.lat = lat_all(3'd1);
    #1;
    vec_cnt++;
    if (gtup !== {8'h30, 1'b1, 3'd4, 1'b1, 3'd5}) begin
      err_cnt++; $display("FAIL flush_grant got %h want %h", gtup, {8'h30, 1'b1, 3'd4, 1'b1, 3'd5});
    end
    step();
    bif.flush = 1'b0; bif.req = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vec_cnt++;
      if (bif.wb_cnt !== 2'd0) begin err_cnt++; $display("FAIL flush_wb%0d got %0d want 0", i, bif.wb_cnt); end
      step();
    end
    bif.req = 8'h03; bif.lat = lat_all(3'd2);
    #1;
    vec_cnt++;
    if (gtup !== {8'h03, 1'b1, 3'd0, 1'b1, 3'd1}) begin
      err_cnt++; $display("FAIL fs_pre got %h want %h", gtup, {8'h03, 1'b1, 3'd0, 1'b1, 3'd1});
    end
    step();
    bif.flush = 1'b1; bif.stall = 1'b1; bif.req = 8'hFF;
    #1;
    vec_cnt++;
    if (gtup !== 16'h0) begin err_cnt++; $display("FAIL fs_nogrant got %h want 0", gtup); end
    step();
    bif.flush = 1'b0; bif.stall = 1'b0; bif.req = '0;
    #1;
    vec_cnt++;
    if (bif.wb_cnt !== 2'd0) begin err_cnt++; $display("FAIL fs_wb got %0d want 0", bif.wb_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bif.req = 8'h30; bif.lat = lat_all(3'd2);
    #1;
    vec_cnt++;
    if (gtup !== {8'h30, 1'b1, 3'd4, 1'b1, 3'd5}) begin
      err_cnt++; $display("FAIL rmid_pre got %h want %h", gtup, {8'h30, 1'b1, 3'd4, 1'b1, 3'd5});
    end
    step();
    reset = 1'b1; bif.req = 8'hFF; bif.lat = lat_all(3'd1);
    #1;
    vec_cnt++;
    if (gtup !== 16'h0) begin err_cnt++; $display("FAIL rmid_nogrant got %h want 0", gtup); end
    step();
    reset = 1'b0;
    #1;
    vec_cnt++;
    if (bif.wb_cnt !== 2'd0) begin err_cnt++; $display("FAIL rmid_wb got %0d want 0", bif.wb_cnt); end
    vec_cnt++;
    if (gtup !== {8'h03, 1'b1, 3'd0, 1'b1, 3'd1}) begin
      err_cnt++; $display("FAIL rmid_rr got %h want %h", gtup, {8'h03, 1'b1, 3'd0, 1'b1, 3'd1});
    end
    step();
    bif.req = '0;
    #1;
    vec_cnt++;
    if (bif.wb_cnt !== 2'd2) begin err_cnt++; $display("FAIL rmid_wb_after got %0d want 2", bif.wb_cnt); end
  endtask

  initial begin
    reset = 1'b1;
    bif.req = '0; bif.lat = '0; bif.stall = 1'b0; bif.flush = 1'b0;
    test_reset();
    test_basic();
    test_rr_wrap();
    test_capacity();
    test_equal_lat();
    test_illegal_lat();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/issue_select_arbiter.md
Name: issue_select_arbiter

Overview:
- Select stage between the reservation-station wakeup logic and the two issue/broadcast slots.
- Each cycle, picks up to two ready requesters in round-robin order.
- Keeps a writeback-slot reservation table so that no more than two results complete in any future cycle, whatever mix of ALU, branch, MUL and LDST latencies is issued.
- Granted indices drive the scoreboard's tag-broadcast inputs (inst_issued_1/2, bc_dst_1/2) upstream.

Parameters:
- NUM_REQ, 8, number of requesting RS entries.
- IDX_W, 3, index width; must be at least log2(NUM_REQ).
- MAX_LATENCY, 4, largest execution latency in cycles; equals the reservation table depth.
- LAT_W, 3, width of each per-requester latency field.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-entry request; entry is ready and wants to issue.
- lat  in  NUM_REQ*LAT_W  packed latency of each entry, entry i at bits [i*LAT_W +: LAT_W].
- stall  in  1  suppresses all grants this cycle.
- flush  in  1  kills in-flight writeback reservations.
- gnt_vec  out  NUM_REQ  one-hot-or-two grant vector, combinational.
- gnt1_valid  out  1  first grant valid.
- gnt1_idx  out  IDX_W  first grant index.
- gnt2_valid  out  1  second grant valid.
- gnt2_idx  out  IDX_W  second grant index.
- wb_cnt  out  2  writebacks occurring in the current cycle (0..2), registered.

Behaviour:
- State: rr_ptr (IDX_W bits) and res[d] for d=0..MAX_LATENCY-1 (2 bits each).
  - res[d] is the number of writebacks scheduled for cycle t+d.
  - res[MAX_LATENCY] reads as constant 0.
- Eligibility of entry i:
  - req[i]=1, 1 <= lat_i <= MAX_LATENCY, and res[lat_i] plus same-cycle earlier grants with equal latency is less than 2.
  - lat 0 or lat > MAX_LATENCY: entry is never granted.
- Selection (combinational, same cycle as req):
  - Scan from rr_ptr upward, wrapping modulo NUM_REQ.
  - First eligible entry becomes grant1; next eligible entry after it becomes grant2, with the equal-latency capacity rechecked against grant1.
  - gnt2_valid=1 implies gnt1_valid=1.
  - Invalid index outputs are 0.
  - gnt_vec has 0, 1 or 2 bits set.
- stall=1 or reset=1: no grants (all grant outputs 0).
- rr_ptr update on the clock edge:
  - After 2 grants: (gnt2_idx+1) mod NUM_REQ.
  - After 1 grant: (gnt1_idx+1) mod NUM_REQ.
  - After 0 grants: unchanged.
  - flush does not change rr_ptr.
- Table update every edge, including during stall:
  - res'[d] = res[d+1] + number of this cycle's grants with lat==d+1, for d=0..MAX_LATENCY-1.
  - Sum never exceeds 2, guaranteed by the eligibility rule.
- wb_cnt equals res[0].
- flush=1:
  - Next-cycle table is all zero; this cycle's grants are discarded from the table.
  - Grant outputs are still produced combinationally this cycle; the upstream block ignores them.
- flush and stall together: flush behaviour applies and the table is cleared.
- Reset, including mid-operation:
  - Next cycle rr_ptr=0, all res=0, wb_cnt=0.
  - No grants while reset is asserted.
- Latency 1: a grant issued in cycle t is counted in wb_cnt at t+1.

Optional Feature:
- Macro: ISSUE_SEL_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_grant_cnt (32 bits): increments by the number of grants each non-stall, non-flush cycle.
  - perf_block_cnt (32 bits): increments by 1 each cycle in which at least one req with legal latency is set, but that entry is denied solely because of writeback capacity.
- Both counters wrap at 2^32 and clear on reset.
- When undefined, neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- After reset, req=8'b0000_0110, all lat=1 -> gnt1_idx=1, gnt2_idx=2, gnt_vec=8'b0000_0110; next cycle rr_ptr=3 and wb_cnt=2.
- rr_ptr=3, req=8'hFF, lat all 1 -> grants 3 and 4, next rr_ptr=5; repeat -> grants 5 and 6, then 7 and 0 (wrap).
- Cycle 0: req 0,1 with lat=3, both granted. Cycle 1: req 2 lat=2 and req 3 lat=1 -> only 3 granted (2 blocked). Cycle 3: wb_cnt=2.
- req 0,1,2 all lat=4, empty table -> grants 0 and 1; next cycle req 2 lat=4 -> granted; wb_cnt reaches 2 then 1 on consecutive cycles.
- stall=1 with req=8'hFF for 3 cycles after 2 lat=2 grants -> no grants, rr_ptr frozen, wb_cnt=2 on the second cycle and 0 afterwards.
- flush after 2 lat=4 grants -> wb_cnt stays 0 for 4 cycles; reset asserted mid-stream -> rr_ptr=0, wb_cnt=0 next cycle.
